// File: rtl/pin_entry_buffer.sv
// Keypad PIN assembler: one event per key press, digit editing,
// valid/ack hand-off of the finished PIN and an inactivity timeout.
module pin_entry_buffer #(
    parameter int unsigned   MAX_DIGITS     = 8,
    parameter int unsigned   TIMEOUT_CYCLES = 50000000,
    parameter logic [3:0]    KEY_ENTER      = 4'd15,
    parameter logic [3:0]    KEY_BACK       = 4'd14,
    parameter logic [3:0]    KEY_CLEAR      = 4'd12
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [3:0]                           tecla_value,
    input  logic                                 tecla_valid,
    input  logic                                 pin_ack,
    output logic [4*MAX_DIGITS-1:0]              pin_digits,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      pin_len,
    output logic                                 pin_valid,
    output logic                                 entry_active,
    output logic                                 key_pulse,
    output logic                                 timeout_pulse
);

    localparam int DW = 4 * MAX_DIGITS;
    localparam int LW = $clog2(MAX_DIGITS + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_DIGITS);
    localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dig_q, dig_d;
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q;
    logic          kp_q, kp_d;
    logic          to_q, to_d;
    logic          pv_q, act_q;

    logic ev;
    logic is_digit;

    assign ev       = tecla_valid & ~valid_q;
    assign is_digit = (tecla_value <= 4'd9);

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        len_d   = len_q;
        cnt_d   = '0;
        kp_d    = 1'b0;
        to_d    = 1'b0;
        if (state_q == PRESENT) begin
            // ack wins over any key event arriving in the same cycle
            if (pin_ack) begin
                state_d = IDLE;
                dig_d   = '0;
                len_d   = '0;
            end
        end else begin
            if (ev && is_digit && (len_q < LEN_MAX)) begin
                dig_d   = (dig_q << 4) | DW'(tecla_value);
                len_d   = len_q + LW'(1);
                state_d = COLLECT;
                kp_d    = 1'b1;
            end else if (ev && (tecla_value == KEY_BACK) && (len_q != '0)) begin
                dig_d   = dig_q >> 4;
                len_d   = len_q - LW'(1);
                state_d = (len_q == LW'(1)) ? IDLE : COLLECT;
                kp_d    = 1'b1;
            end else if (ev && (tecla_value == KEY_CLEAR)) begin
                dig_d   = '0;
                len_d   = '0;
                state_d = IDLE;
                kp_d    = 1'b1;
            end else if (ev && (tecla_value == KEY_ENTER) && (len_q != '0)) begin
                state_d = PRESENT;
                kp_d    = 1'b1;
            end else if ((state_q == COLLECT) && (cnt_q == CNT_END)) begin
                dig_d   = '0;
                len_d   = '0;
                state_d = IDLE;
                to_d    = 1'b1;
            end
            if (!kp_d && (state_q == COLLECT) && (state_d == COLLECT)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            dig_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            kp_q    <= 1'b0;
            to_q    <= 1'b0;
            pv_q    <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            valid_q <= tecla_valid;
            kp_q    <= kp_d;
            to_q    <= to_d;
            pv_q    <= (state_d == PRESENT);
            act_q   <= (state_d == COLLECT);
        end
    end

    assign pin_digits    = dig_q;
    assign pin_len       = len_q;
    assign pin_valid     = pv_q;
    assign entry_active  = act_q;
    assign key_pulse     = kp_q;
    assign timeout_pulse = to_q;

endmodule

// File: tb/tb_pin_entry_buffer.sv
// Directed bench for pin_entry_buffer: a behavioural key model pushes
// expected buffer snapshots to a queue, popped once each press settles.
module tb_pin_entry_buffer;

    localparam int MAXD = 8;
    localparam int TO   = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  tecla_value;
    logic        tecla_valid;
    logic        pin_ack;
    logic [31:0] pin_digits;
    logic [3:0]  pin_len;
    logic        pin_valid;
    logic        entry_active;
    logic        key_pulse;
    logic        timeout_pulse;

    pin_entry_buffer #(
        .MAX_DIGITS(MAXD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tecla_value(tecla_value),
        .tecla_valid(tecla_valid),
        .pin_ack(pin_ack),
        .pin_digits(pin_digits),
        .pin_len(pin_len),
        .pin_valid(pin_valid),
        .entry_active(entry_active),
        .key_pulse(key_pulse),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  len;
        logic        v;
        int          kp;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int kp_cnt = 0;
    int to_cnt = 0;
    int kp_cyc = 0;
    int to_cyc = 0;

    // behavioural model state
    logic [31:0] m_d = '0;
    logic [3:0]  m_len = '0;
    logic        m_pres = 1'b0;
    int          m_kp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_pulse) begin
            kp_cnt = kp_cnt + 1;
            kp_cyc = cyc;
        end
        if (timeout_pulse) begin
            to_cnt = to_cnt + 1;
            to_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_key(input logic [3:0] v);
        if (m_pres) begin
        end else if (v <= 4'd9) begin
            if (m_len < 4'(MAXD)) begin
                m_d   = (m_d << 4) | 32'(v);
                m_len = m_len + 4'd1;
                m_kp++;
            end
        end else if (v == 4'd14) begin
            if (m_len != 0) begin
                m_d   = m_d >> 4;
                m_len = m_len - 4'd1;
                m_kp++;
            end
        end else if (v == 4'd12) begin
            m_d   = '0;
            m_len = '0;
            m_kp++;
        end else if (v == 4'd15) begin
            if (m_len != 0) begin
                m_pres = 1'b1;
                m_kp++;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.d   = m_d;
        e.len = m_len;
        e.v   = m_pres;
        e.kp  = m_kp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_digits"}, 64'(pin_digits), 64'(e.d));
            chk({tag, "_len"}, 64'(pin_len), 64'(e.len));
            chk({tag, "_valid"}, 64'(pin_valid), 64'(e.v));
            chk({tag, "_kp"}, 64'(kp_cnt), 64'(e.kp));
        end
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        tecla_value = v;
        tecla_valid = 1'b1;
        model_key(v);
        push_exp();
        repeat (hold) @(negedge clk);
        tecla_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        tecla_value = 4'd0;
        tecla_valid = 1'b0;
        pin_ack     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digits", 64'(pin_digits), 64'h0);
        chk("rst_len", 64'(pin_len), 64'h0);
        chk("rst_flags", 64'({pin_valid, entry_active, key_pulse,
                              timeout_pulse}), 64'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // T1: 1,2,3,4,# held 10 cycles each
        press(4'd1, 10);
        chk("t1_active", 64'(entry_active), 64'h1);
        void'(sb.pop_front());
        press(4'd2, 10);
        void'(sb.pop_front());
        press(4'd3, 10);
        void'(sb.pop_front());
        press(4'd4, 10);
        pop_cmp("t1_4dig");
        press(4'd15, 10);
        pop_cmp("t1_enter");
        chk("t1_kp5", 64'(kp_cnt), 64'd5);
        chk("t1_1234", 64'(pin_digits[15:0]), 64'h1234);

        // T2: key in PRESENT dropped, then ack clears next cycle
        press(4'd7, 3);
        pop_cmp("t2_key_in_present");
        pin_ack = 1'b1;
        @(negedge clk);
        pin_ack = 1'b0;
        m_pres = 1'b0;
        m_d    = '0;
        m_len  = '0;
        push_exp();
        pop_cmp("t2_ack");

        // T3: nine digits into an 8-digit buffer, then backspace
        for (int i = 1; i <= 8; i++) begin
            press(4'(i), 3);
            void'(sb.pop_front());
        end
        press(4'd9, 3);
        pop_cmp("t3_9th_dropped");
        chk("t3_full", 64'(pin_digits), 64'h12345678);
        press(4'd14, 3);
        pop_cmp("t3_back");
        chk("t3_len7", 64'(pin_len), 64'd7);
        press(4'd12, 3);
        pop_cmp("t3_clear");

        // T4: enter/back/unused code on empty buffer
        press(4'd15, 3);
        pop_cmp("t4_enter_empty");
        press(4'd14, 3);
        pop_cmp("t4_back_empty");
        press(4'd10, 3);
        pop_cmp("t4_code10");

        // T5: timeout fires TO cycles after the accepted digit
        press(4'd5, 1);
        void'(sb.pop_front());
        for (int i = 0; i < 2 * TO; i++) begin
            if (to_cnt == 0) @(negedge clk);
        end
        chk("t5_to_seen", 64'(to_cnt), 64'd1);
        chk("t5_to_delay", 64'(to_cyc - kp_cyc), 64'(TO));
        chk("t5_len0", 64'(pin_len), 64'h0);
        chk("t5_idle", 64'(entry_active), 64'h0);
        m_d   = '0;
        m_len = '0;

        // key landing on the expiry edge keeps the buffer
        press(4'd5, 1);
        void'(sb.pop_front());
        repeat (TO - 3) @(negedge clk);
        press(4'd6, 1);
        pop_cmp("t5_key_at_expiry");
        chk("t5_no_to", 64'(to_cnt), 64'd1);
        press(4'd12, 1);
        pop_cmp("t5_clear");

        // T6: key held across reset gives no event until re-pressed
        press(4'd1, 2);
        void'(sb.pop_front());
        tecla_value = 4'd3;
        tecla_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        kp_cnt = 0;
        repeat (1000) @(negedge clk);
        chk("t6_len_after_rst", 64'(pin_len), 64'h0);
        chk("t6_kp_after_rst", 64'(kp_cnt), 64'h0);
        tecla_valid = 1'b0;
        repeat (2) @(negedge clk);
        tecla_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_one_digit", 64'(pin_len), 64'h1);
        chk("t6_digit_val", 64'(pin_digits), 64'h3);
        repeat (995) @(negedge clk);
        tecla_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_one_pulse", 64'(kp_cnt), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
